// File: rtl/comp_pkg.sv
// Shared types for the sequential magnitude comparator: FSM states, one-hot result
// encoding, and the slice-index width helper.
package comp_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        CMP  = 1'b1
    } state_t;

    // Bit order matches the {gt, eq, lt} output flags
    typedef enum logic [2:0] {
        RES_NONE = 3'b000,
        RES_LT   = 3'b001,
        RES_EQ   = 3'b010,
        RES_GT   = 3'b100
    } res_t;

    function automatic int idx_bits(input int width, input int digit);
        int d;
        d = width / digit;
        return (d <= 1) ? 1 : $clog2(d);
    endfunction

endpackage

// File: rtl/digit_cmp.sv
// Purpose: unsigned DIGIT-bit slice compare producing gt/eq/lt.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module digit_cmp #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    assign gt = (a > b);
    assign eq = (a == b);
    assign lt = (a < b);

endmodule

// File: rtl/seq_mag_comp.sv
// Purpose: WIDTH-bit magnitude compare, one DIGIT slice per cycle MSB first, early exit;
// signed compare is available when COMP_SIGNED_EN is defined.
// Latency: 1..WIDTH/DIGIT cycles from accepted start to done.
// Backpressure: start is ignored while busy=1; results are held until the next done.
module seq_mag_comp
    import comp_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
`ifdef COMP_SIGNED_EN
    input  logic             signed_mode,
`endif
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             eq,
    output logic             lt
);

    localparam int D  = WIDTH / DIGIT;
    localparam int IW = idx_bits(WIDTH, DIGIT);
    localparam logic [IW-1:0]    TOP_IDX  = IW'(D - 1);
    localparam logic [DIGIT-1:0] MSB_MASK = DIGIT'(1) << (DIGIT - 1);

    if (WIDTH % DIGIT != 0) begin : g_bad_width
        $error("seq_mag_comp: WIDTH must be a multiple of DIGIT");
    end

    state_t           state;
    logic [IW-1:0]    idx;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    res_t             res_q;
    logic             flip_msb;
    logic [DIGIT-1:0] a_sl;
    logic [DIGIT-1:0] b_sl;
    logic             s_gt;
    logic             s_eq;
    logic             s_lt;

`ifdef COMP_SIGNED_EN
    logic sgn_q;
    // Flipping the sign bit maps two's complement onto offset binary for the top slice
    assign flip_msb = sgn_q && (idx == TOP_IDX);
`else
    assign flip_msb = 1'b0;
`endif

    always_comb begin
        a_sl = DIGIT'(a_q >> (int'(idx) * DIGIT));
        b_sl = DIGIT'(b_q >> (int'(idx) * DIGIT));
        if (flip_msb) begin
            a_sl = a_sl ^ MSB_MASK;
            b_sl = b_sl ^ MSB_MASK;
        end
    end

    digit_cmp #(.DIGIT(DIGIT)) u_digit_cmp (
        .a  (a_sl),
        .b  (b_sl),
        .gt (s_gt),
        .eq (s_eq),
        .lt (s_lt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            idx   <= '0;
            a_q   <= '0;
            b_q   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            res_q <= RES_NONE;
`ifdef COMP_SIGNED_EN
            sgn_q <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        a_q   <= a;
                        b_q   <= b;
`ifdef COMP_SIGNED_EN
                        sgn_q <= signed_mode;
`endif
                        idx   <= TOP_IDX;
                        busy  <= 1'b1;
                        state <= CMP;
                    end
                end
                CMP: begin
                    if (!s_eq) begin
                        res_q <= s_gt ? RES_GT : RES_LT;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else if (idx == '0) begin
                        res_q <= RES_EQ;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        idx <= idx - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign {gt, eq, lt} = res_q;

    // Lowest slice-compare lt is implied by !gt && !eq
    logic unused_ok;
    assign unused_ok = s_lt;

endmodule

// File: tb/tb_seq_mag_comp.sv
// Bench for seq_mag_comp (WIDTH=16, DIGIT=4): transaction-level reference model checked
// every cycle, plus directed scenarios with literal latency/result expectations.
module tb_seq_mag_comp;

    localparam int WIDTH = 16;
    localparam int DIGIT = 4;
    localparam int D     = WIDTH / DIGIT;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] a_i = '0;
    logic [WIDTH-1:0] b_i = '0;
    logic             sgn_i = 1'b0;
    logic             busy, done, gt, eq, lt;

    int chk_cnt  = 0;
    int pass_cnt = 0;

    seq_mag_comp #(.WIDTH(WIDTH), .DIGIT(DIGIT)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .a           (a_i),
        .b           (b_i),
`ifdef COMP_SIGNED_EN
        .signed_mode (sgn_i),
`endif
        .busy        (busy),
        .done        (done),
        .gt          (gt),
        .eq          (eq),
        .lt          (lt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    // ---------------- reference model (transaction level) ----------------
    function automatic int decide_k(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y);
        for (int i = 1; i <= D; i++) begin
            if (((x >> (WIDTH - i * DIGIT)) & ((1 << DIGIT) - 1)) !=
                ((y >> (WIDTH - i * DIGIT)) & ((1 << DIGIT) - 1)))
                return i;
        end
        return D;
    endfunction

    function automatic logic [2:0] ref_res(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                                           input logic s);
        logic greater;
        greater = s ? ($signed(x) > $signed(y)) : (x > y);
        if (x == y)   return 3'b010;
        if (greater)  return 3'b100;
        return 3'b001;
    endfunction

    logic       m_busy = 1'b0;
    logic       m_done = 1'b0;
    logic [2:0] m_res  = 3'b000;
    logic [2:0] m_pend = 3'b000;
    int         m_left = 0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy = 1'b0;
            m_done = 1'b0;
            m_res  = 3'b000;
            m_left = 0;
        end else begin
            m_done = 1'b0;
            if (m_busy) begin
                m_left--;
                if (m_left == 0) begin
                    m_busy = 1'b0;
                    m_done = 1'b1;
                    m_res  = m_pend;
                end
            end else if (start) begin
                m_busy = 1'b1;
                m_left = decide_k(a_i, b_i);
`ifdef COMP_SIGNED_EN
                m_pend = ref_res(a_i, b_i, sgn_i);
`else
                m_pend = ref_res(a_i, b_i, 1'b0);
`endif
            end
        end
    end

    always @(negedge clk) begin
        check("model_cycle", {27'd0, busy, done, gt, eq, lt}, {27'd0, m_busy, m_done, m_res});
    end

    // ---------------- directed helpers ----------------
    task automatic issue(input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y, input logic s);
        start = 1'b1;
        a_i   = x;
        b_i   = y;
        sgn_i = s;
    endtask

    // Called at the negedge right after acceptance; returns at the negedge showing done.
    task automatic wait_done(input string name, input int exp_k, input logic [2:0] exp_res);
        int cnt;
        cnt = 0;
        while (done !== 1'b1 && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        check({name, "_latency"}, cnt, exp_k);
        check({name, "_result"}, {29'd0, gt, eq, lt}, {29'd0, exp_res});
        check({name, "_busy_low"}, {31'd0, busy}, 32'd0);
    endtask

    task automatic run_cmp(input string name, input logic [WIDTH-1:0] x, input logic [WIDTH-1:0] y,
                           input logic s, input int exp_k, input logic [2:0] exp_res);
        @(negedge clk);
        issue(x, y, s);
        @(negedge clk);
        start = 1'b0;
        wait_done(name, exp_k, exp_res);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        @(negedge clk);
        check("reset_outputs", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        #2 rst_n = 1'b1;
        @(negedge clk);
        check("idle_after_reset", {27'd0, busy, done, gt, eq, lt}, 32'd0);

        // Equal operands take all four slices
        run_cmp("equal", 16'h1234, 16'h1234, 1'b0, 4, 3'b010);
        // Decided on the top slice
        run_cmp("early_exit", 16'h8000, 16'h7FFF, 1'b0, 1, 3'b100);
        // Decided on the last slice, then back-to-back start in the done cycle
        run_cmp("late_lt", 16'h1234, 16'h1235, 1'b0, 4, 3'b001);
        issue(16'h1235, 16'h1234, 1'b0);
        @(negedge clk);
        start = 1'b0;
        check("b2b_accepted", {31'd0, busy}, 32'd1);
        wait_done("b2b_gt", 4, 3'b100);
        run_cmp("mid_slice", 16'h12F0, 16'h1200, 1'b0, 3, 3'b100);

        // start held high and operands toggling while busy
        @(negedge clk);
        issue(16'hABCD, 16'hABCD, 1'b0);
        @(negedge clk);
        begin
            int cnt;
            cnt = 0;
            while (done !== 1'b1 && cnt < 40) begin
                start = 1'b1;
                a_i   = WIDTH'($urandom);
                b_i   = WIDTH'($urandom);
                @(negedge clk);
                cnt++;
            end
            start = 1'b0;
            check("busy_start_latency", cnt, 4);
            check("busy_start_result", {29'd0, gt, eq, lt}, 32'd2);
        end
        @(negedge clk);
        check("no_queued_start", {31'd0, busy}, 32'd0);

`ifdef COMP_SIGNED_EN
        run_cmp("signed_neg", 16'h8000, 16'h0001, 1'b1, 1, 3'b001);
        run_cmp("unsigned_big", 16'h8000, 16'h0001, 1'b0, 1, 3'b100);
        run_cmp("signed_low", 16'hFFF0, 16'hFFF3, 1'b1, 4, 3'b001);
`endif

        // Reset pulse during an equal-operand compare
        @(negedge clk);
        issue(16'h5555, 16'h5555, 1'b0);
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("reset_abort", {27'd0, busy, done, gt, eq, lt}, 32'd0);
        #1 rst_n = 1'b1;
        begin
            int seen;
            seen = 0;
            repeat (6) begin
                @(negedge clk);
                if (done === 1'b1) seen++;
            end
            check("no_done_after_abort", seen, 0);
        end
        run_cmp("after_reset", 16'h0F00, 16'h0E00, 1'b0, 2, 3'b100);

        // Random traffic; the model compare process checks every cycle
        for (int n = 0; n < 2000; n++) begin
            @(negedge clk);
            start = ($urandom_range(0, 3) != 0);
            a_i   = WIDTH'($urandom);
            case ($urandom_range(0, 3))
                0:       b_i = a_i;
                1:       b_i = a_i ^ (WIDTH'(1) << $urandom_range(0, WIDTH - 1));
                2:       b_i = a_i ^ WIDTH'($urandom_range(0, 15));
                default: b_i = WIDTH'($urandom);
            endcase
            sgn_i = 1'($urandom_range(0, 1));
        end
        @(negedge clk);
        start = 1'b0;
        repeat (D + 2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
